// File: rtl/aes_ctr_sequencer.sv
// Producer-side front end for the AES-256 CTR wrapper: packs 32-bit words into
// 128-bit blocks and issues each block with its counter value, then waits for drain.
module aes_ctr_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [127:0]         cmd_iv,
    input  logic [LEN_WIDTH-1:0] cmd_blocks,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic                 aes_in_valid,
    input  logic                 aes_in_ready,
    output logic [127:0]         aes_in_block,
    output logic [127:0]         aes_ctr,
    input  logic                 aes_empty,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, FILL, SEND, DRAIN} state_t;

    // Only the low CNT_WIDTH bits of the counter block increment.
    localparam logic [127:0]         CNT_MASK = {128{1'b1}} >> (128 - CNT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic [127:0]           ctr;
    logic [127:0]           blk;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [1:0]             word_idx;
    logic                   done_r;
    logic                   cmd_fire, s_fire, aes_fire, zero_job;

    function automatic logic [127:0] ctr_inc(input logic [127:0] c);
        return (c & ~CNT_MASK) | ((c + 128'd1) & CNT_MASK);
    endfunction

    assign cmd_fire     = cmd_valid & cmd_ready;
    assign s_fire       = s_valid & s_ready;
    assign aes_fire     = aes_in_valid & aes_in_ready;
    assign zero_job     = (cmd_blocks == '0);
    assign aes_in_block = blk;
    assign aes_ctr      = ctr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && !zero_job) state_nxt = FILL;
            FILL:    if (s_fire && word_idx == 2'd3) state_nxt = SEND;
            SEND:    if (aes_fire) state_nxt = (remaining == LEN_ONE) ? DRAIN : FILL;
            DRAIN:   if (aes_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are forced low while rst is held, whatever the state.
    always_comb begin
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        aes_in_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        if (!rst) begin
            cmd_ready    = (state == IDLE);
            s_ready      = (state == FILL);
            aes_in_valid = (state == SEND);
            busy         = (state != IDLE);
            done         = done_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr       <= '0;
            blk       <= '0;
            remaining <= '0;
            word_idx  <= 2'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (cmd_fire && zero_job) || (state == DRAIN && aes_empty);
            if (cmd_fire && !zero_job) begin
                ctr       <= cmd_iv;
                remaining <= cmd_blocks;
                word_idx  <= 2'd0;
            end
            // Word 0 lands in the most significant lane; index wraps to 0 after word 3.
            if (s_fire) begin
                case (word_idx)
                    2'd0: blk[127:96] <= s_data;
                    2'd1: blk[95:64]  <= s_data;
                    2'd2: blk[63:32]  <= s_data;
                    default: blk[31:0] <= s_data;
                endcase
                word_idx <= word_idx + 2'd1;
            end
            if (aes_fire) begin
                ctr       <= ctr_inc(ctr);
                remaining <= remaining - LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer: scoreboard of expected {block, ctr}
// pairs, popped by a monitor on every aes_in handshake.
module tb_aes_ctr_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] cmd_iv;
    logic [15:0]  cmd_blocks;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         aes_in_valid;
    logic         aes_in_ready;
    logic [127:0] aes_in_block;
    logic [127:0] aes_ctr;
    logic         aes_empty;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [255:0] sb_q[$];

    aes_ctr_sequencer #(.CNT_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_iv(cmd_iv), .cmd_blocks(cmd_blocks),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready),
        .aes_in_block(aes_in_block), .aes_ctr(aes_ctr),
        .aes_empty(aes_empty), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge shows what the next edge samples.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (!rst && aes_in_valid === 1'b1 && aes_in_ready === 1'b1) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_block", aes_in_block, 128'h0);
                check("unexpected_ctr", aes_ctr, 128'h0);
            end else begin
                logic [255:0] e;
                e = sb_q.pop_front();
                check("block", aes_in_block, e[255:128]);
                check("ctr", aes_ctr, e[127:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [127:0] iv, input logic [15:0] n);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_iv = iv; cmd_blocks = n;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (ok) tick();
        else check("cmd_timeout", 128'h0, 128'h1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        bit ok = 0;
        if (gap) begin s_valid = 1'b0; tick(); end
        s_valid = 1'b1; s_data = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
        end
        if (ok) tick();
        else check("word_timeout", 128'h0, 128'h1);
        s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b, input bit gap);
        send_word(b[127:96], gap);
        send_word(b[95:64], gap);
        send_word(b[63:32], gap);
        send_word(b[31:0], gap);
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 100 && hs_cnt < target; i++) tick();
        check("hs_count", 128'(hs_cnt), 128'(target));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && done_cnt < target; i++) tick();
        check("done_count", 128'(done_cnt), 128'(target));
    endtask

    task automatic expect_blk(input logic [127:0] b, input logic [127:0] c);
        sb_q.push_back({b, c});
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'h0);
        check({tag, "_s_ready"}, 128'(s_ready), 128'h0);
        check({tag, "_aes_in_valid"}, 128'(aes_in_valid), 128'h0);
        check({tag, "_busy"}, 128'(busy), 128'h0);
        check({tag, "_done"}, 128'(done), 128'h0);
        check({tag, "_block"}, aes_in_block, 128'h0);
        check({tag, "_ctr"}, aes_ctr, 128'h0);
    endtask

    initial begin
        logic [127:0] iv, b1, b2, b3;
        int h0, d0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_iv = '0; cmd_blocks = '0;
        s_valid = 1'b0; s_data = '0; aes_in_ready = 1'b1; aes_empty = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 128'(cmd_ready), 128'h1);
        tick();

        // Single block, drain gated by aes_empty
        iv = 128'h0123456789ABCDEF_0000000000000005;
        b1 = 128'h00112233445566778899AABBCCDDEEFF;
        h0 = hs_cnt; d0 = done_cnt;
        expect_blk(b1, iv);
        send_cmd(iv, 16'd1);
        send_block(b1, 1'b0);
        wait_hs(h0 + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_busy", 128'(busy), 128'h1);
            check("drain_done", 128'(done), 128'h0);
            check("drain_valid", 128'(aes_in_valid), 128'h0);
        end
        tick();
        aes_empty = 1'b1;
        @(negedge clk);
        check("done_pulse", 128'(done), 128'h0);
        tick();
        @(negedge clk);
        check("done_high", 128'(done), 128'h1);
        check("busy_after_done", 128'(busy), 128'h0);
        repeat (4) tick();
        check("single_done_once", 128'(done_cnt - d0), 128'h1);
        check("single_sb_empty", 128'(sb_q.size()), 128'h0);

        // Backpressure on the second of three blocks
        iv = 128'hA5A5A5A5_5A5A5A5A_00000001_7FFFFFFE;
        b1 = 128'h11111111_22222222_33333333_44444444;
        b2 = 128'hCAFEBABE_DEADBEEF_0BADF00D_FEEDFACE;
        b3 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        h0 = hs_cnt; d0 = done_cnt;
        expect_blk(b1, iv);
        expect_blk(b2, 128'hA5A5A5A5_5A5A5A5A_00000001_7FFFFFFF);
        expect_blk(b3, 128'hA5A5A5A5_5A5A5A5A_00000001_80000000);
        send_cmd(iv, 16'd3);
        send_block(b1, 1'b0);
        wait_hs(h0 + 1);
        aes_in_ready = 1'b0;
        send_block(b2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 128'(aes_in_valid), 128'h1);
            check("stall_s_ready", 128'(s_ready), 128'h0);
            check("stall_block", aes_in_block, b2);
            check("stall_ctr", aes_ctr, 128'hA5A5A5A5_5A5A5A5A_00000001_7FFFFFFF);
            tick();
        end
        aes_in_ready = 1'b1;
        wait_hs(h0 + 2);
        send_block(b3, 1'b0);
        wait_done(d0 + 1);
        repeat (3) tick();
        check("bp_hs_total", 128'(hs_cnt - h0), 128'h3);
        check("bp_sb_empty", 128'(sb_q.size()), 128'h0);

        // Counter wrap of the low field
        iv = 128'hDEADBEEF_00000000_11111111_FFFFFFFF;
        b1 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        b2 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        h0 = hs_cnt; d0 = done_cnt;
        expect_blk(b1, iv);
        expect_blk(b2, 128'hDEADBEEF_00000000_11111111_00000000);
        send_cmd(iv, 16'd2);
        send_block(b1, 1'b0);
        send_block(b2, 1'b0);
        wait_done(d0 + 1);
        check("wrap_sb_empty", 128'(sb_q.size()), 128'h0);

        // Zero-length job
        tick();
        h0 = hs_cnt; d0 = done_cnt;
        send_cmd(128'h5555, 16'd0);
        @(negedge clk);
        check("zero_done_next", 128'(done), 128'h1);
        for (int i = 0; i < 5; i++) begin
            check("zero_s_ready", 128'(s_ready), 128'h0);
            check("zero_valid", 128'(aes_in_valid), 128'h0);
            check("zero_busy", 128'(busy), 128'h0);
            tick();
            @(negedge clk);
        end
        check("zero_done_once", 128'(done_cnt - d0), 128'h1);
        check("zero_no_hs", 128'(hs_cnt - h0), 128'h0);

        // Reset mid-job, then a fresh job
        tick();
        d0 = done_cnt; h0 = hs_cnt;
        send_cmd(128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 16'd2);
        send_word(32'hBAD0BAD0, 1'b0);
        send_word(32'hBAD1BAD1, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_done", 128'(done_cnt - d0), 128'h0);
        iv = 128'h00000000_00000000_00000000_00000042;
        b1 = 128'h76543210_FEDCBA98_13579BDF_2468ACE0;
        expect_blk(b1, iv);
        send_cmd(iv, 16'd1);
        send_block(b1, 1'b0);
        wait_done(d0 + 1);
        check("midrst_hs", 128'(hs_cnt - h0), 128'h1);
        check("midrst_sb_empty", 128'(sb_q.size()), 128'h0);

        // Gapped input stream
        iv = 128'h00000000_00000000_00000000_00000100;
        b1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
        b2 = 128'hE0E1E2E3_F0F1F2F3_01234567_89ABCDEF;
        h0 = hs_cnt; d0 = done_cnt;
        expect_blk(b1, iv);
        expect_blk(b2, 128'h00000000_00000000_00000000_00000101);
        send_cmd(iv, 16'd2);
        send_block(b1, 1'b1);
        send_block(b2, 1'b1);
        wait_done(d0 + 1);
        check("gap_hs", 128'(hs_cnt - h0), 128'h2);
        check("gap_sb_empty", 128'(sb_q.size()), 128'h0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
- Producer-side front end for the pipelined AES-256 CTR FIFO wrapper.
- Accepts a job command: initial counter block (IV/nonce) and block count.
- Packs a 32-bit input word stream into 128-bit plaintext blocks and presents each block to the wrapper's aes_in_* handshake with its counter value.
- After the last block is accepted, waits for the wrapper to report empty, then pulses done.

Parameters:
- CNT_WIDTH, 32: number of low-order counter bits that increment per block (1..128); upper 128-CNT_WIDTH bits stay constant.
- LEN_WIDTH, 16: width of the block-count field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  sequencer can accept a job
- cmd_iv  in  128  initial counter block
- cmd_blocks  in  LEN_WIDTH  number of 128-bit blocks in job
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&s_ready
- s_data  in  32  input word
- aes_in_valid  out  1  block valid toward wrapper
- aes_in_ready  in  1  wrapper accepts block
- aes_in_block  out  128  packed plaintext block
- aes_ctr  out  128  counter block for this plaintext block
- aes_empty  in  1  wrapper has no pending blocks
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse at job completion

Behaviour:
- States: IDLE, FILL, SEND, DRAIN. Reset forces IDLE and clears the counter, remaining-count, word index, block register and done.
- Outputs while rst is high: cmd_ready=0, s_ready=0, aes_in_valid=0, busy=0, done=0. Data outputs aes_in_block and aes_ctr reset to 0.
- IDLE:
  - cmd_ready=1 (and !rst).
  - On cmd handshake with cmd_blocks==0: no state change; done=1 in the next cycle.
  - On cmd handshake with cmd_blocks!=0: latch ctr<=cmd_iv, remaining<=cmd_blocks, word_idx<=0; go to FILL.
- FILL:
  - s_ready=1.
  - Each s handshake writes s_data into the block register: word 0 -> [127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0]. word_idx then increments.
  - The handshake at word_idx==3 sets word_idx<=0 and moves to SEND.
  - Gaps in s_valid are allowed and stall the state with no effect.
- SEND:
  - aes_in_valid=1 and s_ready=0.
  - aes_in_block and aes_ctr are held stable until the handshake, for any number of cycles.
  - On aes_in_valid&aes_in_ready:
    - ctr[CNT_WIDTH-1:0] <= ctr[CNT_WIDTH-1:0]+1 modulo 2^CNT_WIDTH; ctr[127:CNT_WIDTH] unchanged.
    - remaining <= remaining-1.
    - If remaining==1, go to DRAIN; otherwise go to FILL.
- Timing: the first block's handshake can occur at the earliest in the cycle after its 4th word is accepted. Peak throughput is 1 block per 5 cycles.
- DRAIN:
  - All handshake outputs are 0.
  - When aes_empty==1, go to IDLE with done=1 for exactly that first IDLE cycle (registered).
  - aes_empty sampled high in the first DRAIN cycle counts.
  - A cmd accepted in that same IDLE cycle is legal.
- aes_in_valid is never asserted outside SEND. The sequencer never issues more than cmd_blocks blocks per job.
- Counter wrap: low field all-ones -> all-zeros. No carry into the upper bits and no error flag.
- Reset mid-job:
  - The job is abandoned and no done is produced.
  - Partially packed words are discarded.
  - The next job starts at word 0 with its own IV.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Test Plan:
- Single block:
  - Stimulus: cmd_iv=0x0123456789ABCDEF_0000000000000005, cmd_blocks=1; words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Required: aes_in_block=0x00112233445566778899AABBCCDDEEFF, aes_ctr=cmd_iv.
  - Then: after the handshake, busy stays high until aes_empty=1; done is high for exactly one cycle afterward.
- Backpressure:
  - Stimulus: cmd_blocks=3; aes_in_ready held low 10 cycles while the 2nd block is pending.
  - Required: aes_in_block/aes_ctr stable throughout and s_ready=0 during the stall. Counters seen are iv, iv+1, iv+2 (low field); exactly 3 handshakes.
- Counter wrap:
  - Stimulus: cmd_iv=0xDEADBEEF_00000000_11111111_FFFFFFFF, cmd_blocks=2.
  - Required: second aes_ctr=0xDEADBEEF_00000000_11111111_00000000.
- Zero-length job:
  - Stimulus: cmd_blocks=0.
  - Required: done=1 in the next cycle; aes_in_valid and s_ready never asserted; busy stays 0.
- Reset mid-job:
  - Stimulus: rst asserted after 2 words of block 1 are accepted.
  - Required: all outputs return to reset values and no done. A new job with fresh words packs from word 0 and uses the new IV.
- Gapped input:
  - Stimulus: s_valid toggling every other cycle over 2 blocks.
  - Required: blocks packed identically to the ungapped case; no words lost or duplicated.
